// File: rtl/preamble_seq_pkg.sv
// Shared constants and FSM state type for the legacy preamble sequencer.
package preamble_seq_pkg;
    localparam int SHORT_LEN = 160;
    localparam int LONG_LEN  = 160;
    localparam int DW        = 32;
    localparam int AW        = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHORT,
        ST_LONG,
        ST_DONE
    } state_t;
endpackage

// File: rtl/tx_sample_hold_reg.sv
// Output sample register: captures a ROM word on load and holds it, along with
// its valid/last flags, until the sequencer reloads or clears it.
module tx_sample_hold_reg
    import preamble_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          load,
    input  logic [DW-1:0] din,
    input  logic          last_in,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic          last
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout  <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (clear) begin
            dout  <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (load) begin
            dout  <= din;
            valid <= 1'b1;
            last  <= last_in;
        end
    end
endmodule

// File: rtl/preamble_seq.sv
// 802.11a/g legacy preamble sequencer: plays the short then long preamble ROMs
// onto a valid/ready sample stream, one sample per cycle when not back-pressured.
module preamble_seq
    import preamble_seq_pkg::*;
(
    input  logic          clk,
    input  logic          phy_tx_arestn,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] short_addr,
    input  logic [DW-1:0] short_dout,
    output logic [AW-1:0] long_addr,
    input  logic [DW-1:0] long_dout,
    output logic [DW-1:0] sample_out,
    output logic          sample_valid,
    input  logic          sample_ready,
    output logic          sample_last,
    output logic          busy,
    output logic          done
);
    state_t        state, state_nxt;
    logic [AW-1:0] idx, idx_nxt, idx_inc;
    logic          hs, load, clear, last_in, sel_long;

    assign hs      = sample_valid && sample_ready;
    assign idx_inc = idx + 1'b1;
    assign busy    = (state == ST_SHORT) || (state == ST_LONG);
    assign done    = (state == ST_DONE);

    always_ff @(posedge clk or negedge phy_tx_arestn) begin
        if (!phy_tx_arestn) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // The ROM address looks one sample ahead during a handshake so the
    // register reloads in the same edge that retires the current sample.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        load       = 1'b0;
        clear      = 1'b0;
        last_in    = 1'b0;
        sel_long   = 1'b0;
        short_addr = '0;
        long_addr  = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SHORT;
                    idx_nxt   = '0;
                    load      = 1'b1;
                end
            end
            ST_SHORT: begin
                short_addr = idx;
                if (hs) begin
                    load = 1'b1;
                    if (idx == AW'(SHORT_LEN - 1)) begin
                        state_nxt = ST_LONG;
                        idx_nxt   = '0;
                        sel_long  = 1'b1;
                        last_in   = (LONG_LEN == 1);
                    end else begin
                        idx_nxt    = idx_inc;
                        short_addr = idx_inc;
                    end
                end
            end
            ST_LONG: begin
                long_addr = idx;
                sel_long  = 1'b1;
                if (hs) begin
                    if (idx == AW'(LONG_LEN - 1)) begin
                        state_nxt = ST_DONE;
                        idx_nxt   = '0;
                        clear     = 1'b1;
                    end else begin
                        idx_nxt   = idx_inc;
                        long_addr = idx_inc;
                        load      = 1'b1;
                        last_in   = (idx_inc == AW'(LONG_LEN - 1));
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
            load      = 1'b0;
            clear     = 1'b1;
        end
    end

    tx_sample_hold_reg u_hold (
        .clk     (clk),
        .rst_n   (phy_tx_arestn),
        .clear   (clear),
        .load    (load),
        .din     (sel_long ? long_dout : short_dout),
        .last_in (last_in),
        .dout    (sample_out),
        .valid   (sample_valid),
        .last    (sample_last)
    );
endmodule

// File: tb/tb_preamble_seq.sv
// Self-checking bench for preamble_seq: ROM contents are built from the preamble
// structure (repeated short symbol, GI2 + 2x long symbol) and the stream is checked against it.
module tb_preamble_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  short_addr, long_addr;
    logic [31:0] short_dout, long_dout, sample_out;
    logic        sample_valid, sample_last, busy, done;

    logic [31:0] short_rom [256];
    logic [31:0] long_rom  [256];
    logic [31:0] exp_q     [320];
    int tests = 0;
    int fails = 0;

    assign short_dout = short_rom[short_addr];
    assign long_dout  = long_rom[long_addr];

    always #5 clk = ~clk;

    preamble_seq dut (
        .clk           (clk),
        .phy_tx_arestn (rst_n),
        .start         (start),
        .abort         (abort),
        .short_addr    (short_addr),
        .short_dout    (short_dout),
        .long_addr     (long_addr),
        .long_dout     (long_dout),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .sample_ready  (ready),
        .sample_last   (sample_last),
        .busy          (busy),
        .done          (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, sample_valid, 1'b0);
        check({tag, "_last"},  sample_last,  1'b0);
        check({tag, "_busy"},  busy,         1'b0);
        check({tag, "_done"},  done,         1'b0);
    endtask

    // mode 1: ready=1; mode 2: random ready; mode 3: 5-cycle stall on short[159].
    // *_k arguments select the sample index at which to re-pulse start, abort or reset (-1 = never).
    task automatic play(input int mode, input int repulse_k, input int abort_k, input int reset_k);
        int  k, t, stall;
        bit  finished, rdy;
        k = 0; t = 0; stall = 0; finished = 0;
        start = 1'b1;
        ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        t = 1;
        check("busy_after_start", busy, 1'b1);
        while (!finished && t < 3000) begin
            check("valid", sample_valid, 1'b1);
            check("sample", sample_out, exp_q[k]);
            check("last", sample_last, k == 319);
            if (mode != 2 && k == 160 && stall == 0)
                check("long0_cycle", t, 161);
            if (k == reset_k) begin
                rst_n = 1'b0;
                #1;
                check_idle_outputs("async_rst");
                check("async_rst_data", sample_out, 32'h0);
                check("async_rst_saddr", short_addr, 8'h0);
                finished = 1;
            end else begin
                rdy = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (mode == 3 && k == 159 && stall < 5) begin
                    rdy = 1'b0;
                    stall++;
                    check("stall_saddr", short_addr, 8'd159);
                    check("stall_laddr", long_addr, 8'd0);
                end
                start = (k == repulse_k);
                abort = (k == abort_k);
                ready = rdy;
                @(posedge clk); #1;
                t++;
                start = 1'b0;
                if (abort) begin
                    abort = 1'b0;
                    check_idle_outputs("abort");
                    for (int i = 0; i < 5; i++) begin
                        @(posedge clk); #1;
                        check("abort_no_done", done, 1'b0);
                    end
                    finished = 1;
                end else begin
                    if (rdy) k++;
                    if (k == 320) begin
                        check("done_pulse", done, 1'b1);
                        check("done_valid", sample_valid, 1'b0);
                        check("done_busy", busy, 1'b0);
                        if (mode != 2)
                            check("done_cycle", t, (mode == 3) ? 326 : 321);
                        start = 1'b1;
                        ready = 1'b1;
                        @(posedge clk); #1;
                        start = 1'b0;
                        check_idle_outputs("after_done");
                        finished = 1;
                    end
                end
            end
        end
        if (!finished) check("timeout", 1'b0, 1'b1);
        ready = 1'b0;
    endtask

    initial begin
        logic [31:0] s_sym [16];
        logic [31:0] l_sym [64];
        for (int i = 0; i < 16; i++) s_sym[i] = $urandom;
        for (int i = 0; i < 64; i++) l_sym[i] = $urandom;
        l_sym[0]  = 32'h14000000;
        l_sym[32] = 32'hEC000000;
        l_sym[63] = 32'hFF580F67;
        for (int i = 0; i < 256; i++) begin
            short_rom[i] = $urandom;
            long_rom[i]  = $urandom;
        end
        for (int i = 0; i < 160; i++) begin
            short_rom[i] = s_sym[i % 16];
            long_rom[i]  = (i < 32) ? l_sym[i + 32] : l_sym[(i - 32) % 64];
        end
        for (int i = 0; i < 320; i++)
            exp_q[i] = (i < 160) ? short_rom[i] : long_rom[i - 160];

        #1;
        check_idle_outputs("reset");
        check("reset_data", sample_out, 32'h0);
        check("reset_saddr", short_addr, 8'h0);
        check("reset_laddr", long_addr, 8'h0);
        check("model_long0", exp_q[160], 32'hEC000000);
        check("model_long32", exp_q[192], 32'h14000000);
        check("model_long159", exp_q[319], 32'hFF580F67);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("post_reset");

        play(1, -1, -1, -1);
        play(2, -1, -1, -1);
        play(3, -1, -1, -1);
        play(1, 40, -1, -1);
        play(1, -1, 170, -1);
        play(1, -1, -1, -1);
        play(1, -1, -1, 77);
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("in_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("reset_release");
        play(2, -1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
